lcd_panel_rx: RTL

//   Receive-side model of the 4-wire SPI LCD link (sda/scl/cs/rs) driven by the lcd/serialize transmitter.

---
 rtl/lcd_panel_rx_pkg.sv | 34 +++
 rtl/lcd_panel_rx_if.sv | 32 +++
 rtl/lcd_panel_rx_spi_byte_rx.sv | 80 ++++++++
 rtl/lcd_panel_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/lcd_panel_rx_pkg.sv
// Shared definitions for the LCD link receiver: the panel command codes
// (also used by the transmitter), the parser states and a window check.
package lcd_panel_rx_pkg;

  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  // state       | meaning
  // ST_IDLE     | waiting for a command, data bytes ignored
  // ST_CASET_P  | collecting 4 column-bound bytes
  // ST_RASET_P  | collecting 4 row-bound bytes
  // ST_RAMWR_HI | next data byte is a pixel high byte
  // ST_RAMWR_LO | next data byte completes a pixel
  // ST_SKIP     | unknown command, data bytes ignored
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_RASET_P,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_SKIP
  } parse_state_t;

  // A window is usable only if it is ordered and fits on the panel; the
  // compare is done on the full 16-bit wire value before any truncation.
  function automatic logic bound_ok(input logic [15:0] i_lo,
                                    input logic [15:0] i_hi,
                                    input logic [15:0] i_limit);
    return (i_lo <= i_hi) && (i_hi < i_limit);
  endfunction

endpackage

// File: rtl/lcd_panel_rx_if.sv
// Link pins plus the decoded pixel/command outputs of the panel receiver.
// master = transmitter/bench side, slave = receiver side.
interface lcd_panel_rx_if #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 160
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic          sda;
  logic          scl;
  logic          cs;
  logic          rs;
  logic          pix_we;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_color;
  logic          frame_done;
  logic          cmd_strobe;
  logic [7:0]    cmd_byte;
  logic          awake;

  modport master (
    output sda, scl, cs, rs,
    input  pix_we, pix_x, pix_y, pix_color, frame_done, cmd_strobe, cmd_byte, awake
  );

  modport slave (
    input  sda, scl, cs, rs,
    output pix_we, pix_x, pix_y, pix_color, frame_done, cmd_strobe, cmd_byte, awake
  );
endinterface

// File: rtl/lcd_panel_rx_spi_byte_rx.sv
// Oversampling SPI byte framer: synchronises the link pins to cin, detects
// scl rising edges and assembles MSB-first bytes with their rs flag.
module lcd_spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       cin,
  input  logic       reset,
  input  logic       i_sda,
  input  logic       i_scl,
  input  logic       i_cs,
  input  logic       i_rs,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_byte_valid
);

  logic [SYNC_STAGES-1:0] r_sda_sync, r_scl_sync, r_cs_sync, r_rs_sync;
  logic                   r_scl_d, r_cs_d;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [7:0]             r_byte;
  logic                   r_rs;
  logic                   r_byte_valid;
  logic                   w_sda, w_scl, w_cs, w_rs, w_scl_rise, w_cs_rise;

  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_rs       = r_rs_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;

  // Synchronise pins; cs resets deasserted so nothing is framed out of reset.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      r_sda_sync <= '0;
      r_scl_sync <= '0;
      r_cs_sync  <= '1;
      r_rs_sync  <= '0;
      r_scl_d    <= 1'b0;
      r_cs_d     <= 1'b1;
    end else begin
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_rs_sync  <= {r_rs_sync[SYNC_STAGES-2:0], i_rs};
      r_scl_d    <= w_scl;
      r_cs_d     <= w_cs;
    end
  end

  // Shift on each selected scl rise; a cs release drops any partial byte.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte       <= 8'h00;
      r_rs         <= 1'b0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_cs_rise) begin
        r_bit_cnt <= 3'd0;
      end else if (w_scl_rise && !w_cs) begin
        r_shift   <= {r_shift[6:0], w_sda};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte       <= {r_shift[6:0], w_sda};
          r_rs         <= w_rs;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_rs         = r_rs;
  assign o_byte_valid = r_byte_valid;

endmodule

// File: rtl/lcd_panel_rx.sv
// Panel-side receiver for the 4-wire SPI LCD link: decodes SLPOUT, CASET,
// RASET and RAMWR and emits one pixel write per received 16-bit pixel.
module lcd_panel_rx
  import lcd_panel_rx_pkg::*;
#(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 160,
  parameter int SYNC_STAGES = 2
) (
  input logic            cin,
  input logic            reset,
  lcd_panel_rx_if.slave  bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [7:0]    w_byte;
  logic          w_byte_rs;
  logic          w_byte_valid;
  logic [15:0]   w_lo, w_hi;

  parse_state_t  r_state;
  logic [1:0]    r_pcnt;
  logic [7:0]    r_p0, r_p1, r_p2, r_hi;
  logic [XW-1:0] r_xs, r_xe, r_cur_x;
  logic [YW-1:0] r_ys, r_ye, r_cur_y;
  logic          r_pix_we, r_frame_done, r_cmd_strobe, r_awake;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic [15:0]   r_pix_color;
  logic [7:0]    r_cmd_byte;

  lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .cin         (cin),
    .reset       (reset),
    .i_sda       (bus.sda),
    .i_scl       (bus.scl),
    .i_cs        (bus.cs),
    .i_rs        (bus.rs),
    .o_byte      (w_byte),
    .o_rs        (w_byte_rs),
    .o_byte_valid(w_byte_valid)
  );

  // Bounds arrive as {b0,b1} then {b2,b3}; the 4th byte is still on w_byte.
  assign w_lo = {r_p0, r_p1};
  assign w_hi = {r_p2, w_byte};

  // Parser FSM with window, cursor and all registered outputs.
  always_ff @(posedge cin or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pcnt       <= 2'd0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_hi         <= 8'h00;
      r_xs         <= '0;
      r_xe         <= XW'(WIDTH - 1);
      r_ys         <= '0;
      r_ye         <= YW'(HEIGHT - 1);
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_pix_we     <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_color  <= 16'h0000;
      r_frame_done <= 1'b0;
      r_cmd_strobe <= 1'b0;
      r_cmd_byte   <= 8'h00;
      r_awake      <= 1'b0;
    end else begin
      r_pix_we     <= 1'b0;
      r_frame_done <= 1'b0;
      r_cmd_strobe <= 1'b0;
      if (w_byte_valid && !w_byte_rs) begin
        r_cmd_strobe <= 1'b1;
        r_cmd_byte   <= w_byte;
        r_pcnt       <= 2'd0;
        case (w_byte)
          CMD_CASET:  r_state <= ST_CASET_P;
          CMD_RASET:  r_state <= ST_RASET_P;
          CMD_RAMWR: begin
            r_cur_x <= r_xs;
            r_cur_y <= r_ys;
            r_state <= ST_RAMWR_HI;
          end
          CMD_SLPOUT: begin
            r_awake <= 1'b1;
            r_state <= ST_IDLE;
          end
          default:    r_state <= ST_SKIP;
        endcase
      end else if (w_byte_valid) begin
        case (r_state)
          ST_CASET_P, ST_RASET_P: begin
            r_pcnt <= r_pcnt + 2'd1;
            case (r_pcnt)
              2'd0: r_p0 <= w_byte;
              2'd1: r_p1 <= w_byte;
              2'd2: r_p2 <= w_byte;
              default: begin
                if (r_state == ST_CASET_P) begin
                  if (bound_ok(w_lo, w_hi, 16'(WIDTH))) begin
                    r_xs <= w_lo[XW-1:0];
                    r_xe <= w_hi[XW-1:0];
                  end
                end else if (bound_ok(w_lo, w_hi, 16'(HEIGHT))) begin
                  r_ys <= w_lo[YW-1:0];
                  r_ye <= w_hi[YW-1:0];
                end
                r_state <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR_HI: begin
            r_hi    <= w_byte;
            r_state <= ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            r_pix_we    <= 1'b1;
            r_pix_color <= {r_hi, w_byte};
            r_pix_x     <= r_cur_x;
            r_pix_y     <= r_cur_y;
            if (r_cur_x == r_xe) begin
              r_cur_x <= r_xs;
              if (r_cur_y == r_ye) begin
                r_cur_y      <= r_ys;
                r_frame_done <= 1'b1;
              end else begin
                r_cur_y <= r_cur_y + 1'b1;
              end
            end else begin
              r_cur_x <= r_cur_x + 1'b1;
            end
            r_state <= ST_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pix_we     = r_pix_we;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_color  = r_pix_color;
  assign bus.frame_done = r_frame_done;
  assign bus.cmd_strobe = r_cmd_strobe;
  assign bus.cmd_byte   = r_cmd_byte;
  assign bus.awake      = r_awake;

endmodule
